// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: predicts the next fetch PC from the BTB/direction predictor,
// tracks in-flight predictions in a circular queue and redirects on a mispredicted retire.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_predict_taken,
    input  logic        i_btb_valid,
    input  logic [31:0] i_btb_target,
    input  logic        i_ex_retire,
    input  logic        i_ex_is_branch,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    output logic [31:0] o_fetch_pc,
    output logic        o_fetch_valid,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_q_full,
    output logic [15:0] o_branch_count,
    output logic [15:0] o_mispredict_count,
    output logic        o_underflow
);

    localparam int          PW       = $clog2(QDEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(QDEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [31:0]   pc_q, pc_d;
    logic          valid_q;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [15:0]   bcnt_q, bcnt_d, mcnt_q, mcnt_d;
    logic          uf_q, uf_d;

    // The predicted direction is fully implied by the stored predicted next PC,
    // so each entry keeps only the fetch PC and its predicted successor.
    logic [31:0]   q_pc_q [QDEPTH];
    logic [31:0]   q_pn_q [QDEPTH];

    logic          pt, q_full, q_empty, pop, redirect, advance;
    logic [31:0]   pn, hpc, hpn, an;

    always_comb begin
        pt       = i_predict_taken & i_btb_valid;
        pn       = pt ? i_btb_target : pc_q + 32'd4;
        q_full   = (cnt_q == FULL_CNT);
        q_empty  = (cnt_q == '0);
        pop      = i_ex_retire & ~q_empty;
        hpc      = q_pc_q[rd_q];
        hpn      = q_pn_q[rd_q];
        an       = (i_ex_is_branch & i_ex_taken) ? i_ex_target : hpc + 32'd4;
        redirect = pop & (an != hpn) & ~rst;
        advance  = valid_q & ~i_stall & ~q_full & ~redirect;
    end

    always_comb begin
        pc_d   = pc_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        uf_d   = uf_q | (i_ex_retire & q_empty);

        if (redirect) begin
            // Flush: every younger prediction is on the wrong path.
            pc_d  = {an[31:2], 2'b00};
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (advance) begin
                pc_d = pn;
                wr_d = wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
            if (advance && !pop) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (!advance && pop) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        if (pop && i_ex_is_branch && bcnt_q != 16'hFFFF) begin
            bcnt_d = bcnt_q + 16'd1;
        end
        if (redirect && mcnt_q != 16'hFFFF) begin
            mcnt_d = mcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            uf_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
            uf_q    <= uf_d;
        end
    end

    // Entry payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (advance) begin
            q_pc_q[wr_q] <= pc_q;
            q_pn_q[wr_q] <= pn;
        end
    end

    assign o_fetch_pc         = pc_q;
    assign o_fetch_valid      = valid_q;
    assign o_redirect         = redirect;
    assign o_redirect_pc      = {an[31:2], 2'b00};
    assign o_q_full           = q_full;
    assign o_branch_count     = bcnt_q;
    assign o_mispredict_count = mcnt_q;
    assign o_underflow        = uf_q;

endmodule
